request_arbiter8: RTL and testbench

//  Sequential arbiter sharing one resource among 8 requesters; winner picked by 8-to-3

---
 rtl/request_arbiter8.sv | 106 ++++++++++
 tb/tb_request_arbiter8.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/request_arbiter8.sv
// -----------------------------------------------------------------------------
// request_arbiter8
//
// Shares one resource among 8 requesters. The winner is chosen either by fixed
// priority (client 7 highest) or by a rotating round-robin search that starts
// just below the previous winner. A grant is held until the holder drops its
// request or, when MAX_HOLD is non-zero, until the holder has owned the
// resource for MAX_HOLD consecutive cycles. Every release is followed by one
// idle cycle in which the next winner is chosen.
//
// Parameters
//   MAX_HOLD   max consecutive grant cycles per holder, 0 = unlimited (0..255)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   req[7:0]   level-sensitive request vector, req[i] from client i
//   rr_en      1 = round-robin, 0 = fixed priority
//   gnt[7:0]   one-hot grant, all-zero when idle
//   gnt_id     binary index of the granted client, 0 when idle
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse when a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module request_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [0:0] state;
    logic [7:0] hold_cnt;
    logic [2:0] last_id;

    logic [2:0] win_id;
    logic       limit_hit;

    // Winner selection. Fixed priority scans 7 down to 0; round-robin scans
    // from last_id-1 downward with 3-bit wraparound, so the previous winner is
    // the last candidate considered. With last_id = 0 both scans coincide.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned and no latch is inferred.
        win_id = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            logic [2:0] idx;
            idx = rr_en ? (last_id - 3'(k + 1)) : 3'(7 - k);
            // Scanning from the lowest-priority candidate upward lets the
            // last match written be the highest-priority one.
            if (req[idx]) begin
                win_id = idx;
            end
        end
    end

    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= 8'd0;
            last_id   <= 3'd0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            if (req != 8'h00) begin
                state     <= GRANT;
                gnt       <= 8'h01 << win_id;
                gnt_id    <= win_id;
                gnt_valid <= 1'b1;
                hold_cnt  <= 8'd1;
                last_id   <= win_id;
            end
        end else begin
            // Only the holder's own request bit matters while a grant is live;
            // other clients are neither preempting nor remembered.
            if (!req[gnt_id] || limit_hit) begin
                state     <= IDLE;
                gnt       <= 8'h00;
                gnt_id    <= 3'd0;
                gnt_valid <= 1'b0;
                hold_cnt  <= 8'd0;
                timeout   <= req[gnt_id];
            end else if (hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_request_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_request_arbiter8
//
// Self-checking bench for request_arbiter8 (MAX_HOLD = 4). Directed scenarios
// cover reset, fixed priority, round-robin rotation, hold-limit expiry, no
// preemption and asynchronous reset mid-grant; a randomized phase follows.
// Expected outputs come from a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_request_arbiter8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit m_busy;
    int m_holder;
    int m_cnt;
    int m_last;
    bit m_to;

    request_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input bit rr);
        if (!rr) begin
            for (int i = 7; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (m_last - k + 8) % 8;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_holder = 0;
        m_cnt    = 0;
        m_last   = 0;
        m_to     = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input bit rr);
        if (!m_busy) begin
            int w;
            m_to = 0;
            w = pick(r, rr);
            if (w >= 0) begin
                m_busy   = 1;
                m_holder = w;
                m_cnt    = 1;
                m_last   = w;
            end
        end else if (!r[m_holder]) begin
            m_busy = 0;
            m_to   = 0;
        end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
            m_busy = 0;
            m_to   = 1;
        end else if (m_cnt < 255) begin
            m_cnt++;
        end
    endtask

    task automatic compare(input string tag);
        logic [7:0] e_gnt;
        e_gnt = m_busy ? 8'(1 << m_holder) : 8'h00;
        check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
        check({tag, ".gnt_id"},    32'(gnt_id),    m_busy ? 32'(m_holder) : 32'd0);
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
        check({tag, ".timeout"},   32'(timeout),   32'(m_to));
    endtask

    // One clock: drive inputs away from the edge, advance the model at the
    // edge, compare just after it.
    task automatic cycle(input string tag, input logic [7:0] r, input bit rr);
        req   = r;
        rr_en = rr;
        @(posedge clk);
        model_step(r, rr);
        #1;
        compare(tag);
    endtask

    // Assert reset between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare({tag, ".async"});
        @(posedge clk);
        #1;
        compare({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 8'hFF;
        rr_en = 1'b0;
        model_reset();

        // 1: reset with all requests pending, then first grant goes to 7
        #3;
        compare("t1_rst");
        @(posedge clk);
        #1;
        compare("t1_rst_edge");
        rst = 1'b0;
        cycle("t1_first", 8'hFF, 1'b0);
        check("t1_gnt80", 32'(gnt), 32'h80);

        // 2: fixed priority with a bubble between grants
        cycle("t2_rel", 8'h00, 1'b0);
        cycle("t2_g4", 8'h14, 1'b0);
        check("t2_id4", 32'(gnt_id), 32'd4);
        cycle("t2_drop4", 8'h04, 1'b0);
        check("t2_bubble", 32'(gnt_valid), 32'd0);
        cycle("t2_g2", 8'h04, 1'b0);
        check("t2_gnt04", 32'(gnt), 32'h04);
        cycle("t2_end", 8'h00, 1'b0);

        // 3: round-robin rotation from a fresh reset
        do_reset("t3_rst");
        cycle("t3_g7", 8'hFF, 1'b1);
        check("t3_id7", 32'(gnt_id), 32'd7);
        for (int i = 0; i < 8; i++) begin
            cycle("t3_drop", 8'hFF & ~(8'h01 << gnt_id), 1'b1);
            cycle("t3_next", 8'hFF, 1'b1);
            check("t3_seq", 32'(gnt_id), 32'((14 - i) % 8));
        end
        cycle("t3_end", 8'h00, 1'b1);

        // 4: hold limit expiry and re-grant to the same client
        for (int i = 1; i <= 7; i++) begin
            cycle("t4_hold", 8'h01, 1'b1);
            if (i <= 4) check("t4_valid", 32'(gnt_valid), 32'd1);
            if (i == 5) check("t4_timeout", 32'(timeout), 32'd1);
            if (i == 6) check("t4_regrant", 32'(gnt), 32'h01);
        end
        cycle("t4_end", 8'h00, 1'b1);

        // 5: no preemption by a higher-priority client
        cycle("t5_g2", 8'h04, 1'b0);
        cycle("t5_hold", 8'h84, 1'b0);
        cycle("t5_hold", 8'h84, 1'b0);
        check("t5_kept", 32'(gnt), 32'h04);
        cycle("t5_rel", 8'h80, 1'b0);
        cycle("t5_g7", 8'h80, 1'b0);
        check("t5_gnt80", 32'(gnt), 32'h80);
        cycle("t5_end", 8'h00, 1'b0);

        // 6: async reset mid-grant clears the round-robin pointer
        cycle("t6_g4", 8'h10, 1'b1);
        check("t6_gnt10", 32'(gnt), 32'h10);
        do_reset("t6_rst");
        cycle("t6_after", 8'h11, 1'b1);
        check("t6_id4", 32'(gnt_id), 32'd4);
        cycle("t6_end", 8'h00, 1'b1);

        // Randomized phase: holders usually keep requesting so timeouts occur
        begin
            bit rr;
            rr = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic [7:0] r;
                r = 8'($urandom);
                if (m_busy && $urandom_range(0, 3) != 0) r[m_holder] = 1'b1;
                if ($urandom_range(0, 7) == 0) r = 8'h00;
                if ($urandom_range(0, 15) == 0) rr = ~rr;
                if ($urandom_range(0, 199) == 0) begin
                    do_reset("rnd_rst");
                end else begin
                    cycle("rnd", r, rr);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
